fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_if.sv | 34 +++
 rtl/fetch_buffer.sv | 106 ++++++++++
 tb/tb_fetch_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if
// Bundles the fetch-side signals of the fetch buffer: PC/enable/stall/redirect
// from the pipeline, the instruction memory request/response pair, and the
// decode-facing head-of-FIFO outputs plus status flags.
//   master : the pipeline / memory side (drives PC_In, En_PC, stall_pc,
//            PC_Change, Imem_Data; observes everything else)
//   slave  : the fetch buffer itself
interface fetch_buffer_if;
    logic [31:0] PC_In;
    logic        En_PC;
    logic        stall_pc;
    logic        PC_Change;
    logic [31:0] Imem_Data;
    logic [31:0] Imem_Addr;
    logic        Imem_Req;
    logic [31:0] Instr_ID;
    logic [31:0] PC_ID;
    logic [31:0] PC4_ID;
    logic        Valid_ID;
    logic        Buf_Full;
    logic        Ovf_Err;

    modport master (
        output PC_In, En_PC, stall_pc, PC_Change, Imem_Data,
        input  Imem_Addr, Imem_Req, Instr_ID, PC_ID, PC4_ID,
               Valid_ID, Buf_Full, Ovf_Err
    );

    modport slave (
        input  PC_In, En_PC, stall_pc, PC_Change, Imem_Data,
        output Imem_Addr, Imem_Req, Instr_ID, PC_ID, PC4_ID,
               Valid_ID, Buf_Full, Ovf_Err
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Sits between the PC stage and decode. Issues one instruction-memory read per
// enabled, unstalled, non-redirect cycle, tracks the single in-flight response
// and queues returned instructions in a 2-entry FIFO whose head is presented
// to decode. A redirect flushes everything fetched so far.
// Ports:
//   CLK    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_buffer_if.slave (PC/enable/stall/redirect in, memory
//            request/response, decode head outputs, Buf_Full, Ovf_Err)
module fetch_buffer (
    input  logic          CLK,
    input  logic          rst_n,
    fetch_buffer_if.slave bus
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    // In-flight response tracking
    logic        rsp_vld_reg;
    logic [29:0] rsp_pc_reg;   // upper index bits never reach PC_ID

    // FIFO state; slot 0 is always the head
    logic [1:0]  count_reg, count_next;
    logic        ovf_reg, ovf_next;
    logic [31:0] slot_pc_reg    [DEPTH];
    logic [31:0] slot_instr_reg [DEPTH];
    logic [31:0] slot_pc_next   [DEPTH];
    logic [31:0] slot_instr_next[DEPTH];

    logic        imem_req;
    logic        flush;
    logic        valid;
    logic        full;
    logic        push;
    logic        pop;
    logic        drop;
    logic        push_ok;
    logic [1:0]  tail_idx;
    logic [31:0] new_pc;
    logic [DEPTH-1:0] load_new;

    assign imem_req = bus.En_PC & ~bus.stall_pc & ~bus.PC_Change;
    assign flush    = bus.PC_Change;
    assign valid    = (count_reg != 2'd0);
    assign full     = (count_reg == 2'd2);
    assign pop      = valid & ~bus.stall_pc & ~flush;
    assign push     = rsp_vld_reg & ~flush;
    // A push into a full FIFO that is not popping this cycle has nowhere to go
    assign drop     = push & full & ~pop;
    assign push_ok  = push & ~drop;
    // Slot the incoming entry lands in, after any pop has shifted the queue
    assign tail_idx = count_reg - {1'b0, pop};
    assign new_pc   = {rsp_pc_reg, 2'b00};

    assign count_next = flush ? 2'd0 : (count_reg + {1'b0, push_ok} - {1'b0, pop});
    assign ovf_next   = ovf_reg | drop;

    // Per-slot next value: a new entry wins over a shift so that a
    // simultaneous push/pop on a single entry lands the new one at the head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign load_new[gi] = push_ok & (tail_idx == 2'(gi));
            if (gi < DEPTH - 1) begin : g_shift
                assign slot_pc_next[gi]    = load_new[gi] ? new_pc :
                                             pop ? slot_pc_reg[gi+1] : slot_pc_reg[gi];
                assign slot_instr_next[gi] = load_new[gi] ? bus.Imem_Data :
                                             pop ? slot_instr_reg[gi+1] : slot_instr_reg[gi];
            end else begin : g_last
                assign slot_pc_next[gi]    = load_new[gi] ? new_pc : slot_pc_reg[gi];
                assign slot_instr_next[gi] = load_new[gi] ? bus.Imem_Data : slot_instr_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= 2'd0;
            ovf_reg     <= 1'b0;
            rsp_vld_reg <= 1'b0;
            rsp_pc_reg  <= 30'd0;
        end else begin
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
            rsp_vld_reg <= imem_req;
            rsp_pc_reg  <= bus.PC_In[29:0];
        end
    end

    // Payload needs no reset: it is only visible while count_reg says so
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_pc_reg[i]    <= slot_pc_next[i];
            slot_instr_reg[i] <= slot_instr_next[i];
        end
    end

    assign bus.Imem_Addr = bus.PC_In;
    assign bus.Imem_Req  = imem_req;
    assign bus.Valid_ID  = valid;
    assign bus.Buf_Full  = full;
    assign bus.Ovf_Err   = ovf_reg;
    assign bus.Instr_ID  = valid ? slot_instr_reg[0] : NOP;
    assign bus.PC_ID     = valid ? slot_pc_reg[0] : 32'd0;
    assign bus.PC4_ID    = valid ? (slot_pc_reg[0] + 32'd4) : 32'd0;
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
// Drives fetch_buffer cycle by cycle. A scoreboard queue receives the
// expected {byte PC, instruction, visible-from cycle} whenever a request is
// issued and is popped when decode consumes the head; a stimulus table adds
// hand-derived Valid_ID / Buf_Full / PC_ID values. Hand sequences cover PC
// wrap, forced overflow and asynchronous reset mid-stream.
module tb_fetch_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK;
    logic rst_n;

    fetch_buffer_if bus ();

    fetch_buffer dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic        st;
        logic        ch;
        logic        exp_valid;
        logic        exp_full;
        logic [31:0] exp_pc_id;
    } vec_t;

    typedef struct {
        logic [31:0] pcb;
        logic [31:0] instr;
        int          ready;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] prev_pc = 32'd0;
    logic        ovf_exp = 1'b0;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mkv(input logic [31:0] pc, input logic en, st, ch,
                                 input logic ev, ef, input logic [31:0] ep);
        vec_t v;
        v.pc = pc; v.en = en; v.st = st; v.ch = ch;
        v.exp_valid = ev; v.exp_full = ef; v.exp_pc_id = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge,
    // advance the scoreboard, and return just after the next rising edge.
    task automatic step(input vec_t v, input bit tab);
        logic        req_e, e_valid, e_full;
        logic [31:0] e_instr, e_pc, e_pc4;
        int          nready;
        bus.PC_In     = v.pc;
        bus.En_PC     = v.en;
        bus.stall_pc  = v.st;
        bus.PC_Change = v.ch;
        bus.Imem_Data = imem_word(prev_pc);
        prev_pc       = v.pc;
        @(negedge CLK);
        req_e  = v.en & ~v.st & ~v.ch;
        nready = 0;
        foreach (sb[i]) if (sb[i].ready <= cyc) nready++;
        e_valid = (nready > 0);
        e_full  = (nready == 2);
        e_instr = e_valid ? sb[0].instr : NOP;
        e_pc    = e_valid ? sb[0].pcb : 32'd0;
        e_pc4   = e_valid ? sb[0].pcb + 32'd4 : 32'd0;
        $display("cyc %0d pc=%h en=%b st=%b ch=%b req=%b vld=%b instr=%h pc_id=%h full=%b ovf=%b",
                 cyc, v.pc, v.en, v.st, v.ch, bus.Imem_Req, bus.Valid_ID, bus.Instr_ID,
                 bus.PC_ID, bus.Buf_Full, bus.Ovf_Err);
        chk("imem_addr", bus.Imem_Addr, v.pc);
        chk("imem_req",  32'(bus.Imem_Req), 32'(req_e));
        chk("valid_id",  32'(bus.Valid_ID), 32'(e_valid));
        chk("instr_id",  bus.Instr_ID, e_instr);
        chk("pc_id",     bus.PC_ID, e_pc);
        chk("pc4_id",    bus.PC4_ID, e_pc4);
        chk("buf_full",  32'(bus.Buf_Full), 32'(e_full));
        chk("ovf_err",   32'(bus.Ovf_Err), 32'(ovf_exp));
        if (tab) begin
            chk("tab_valid", 32'(bus.Valid_ID), 32'(v.exp_valid));
            chk("tab_full",  32'(bus.Buf_Full), 32'(v.exp_full));
            chk("tab_pc_id", bus.PC_ID, v.exp_pc_id);
        end
        if (rst_n) begin
            if (e_valid && !v.st && !v.ch) void'(sb.pop_front());
            if (v.ch) sb.delete();
            if (req_e) sb.push_back('{{v.pc[29:0], 2'b00}, imem_word(v.pc), cyc + 2});
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input logic [31:0] pc, input logic en, st, ch);
        step(mkv(pc, en, st, ch, 1'b0, 1'b0, 32'd0), 1'b0);
    endtask

    initial begin
        // sequential stream, stall with response in flight, drain with En_PC=0
        vecs.push_back(mkv(32'h00, 1, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h01, 1, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h02, 1, 0, 0, 1, 0, 32'h00));
        vecs.push_back(mkv(32'h03, 1, 0, 0, 1, 0, 32'h04));
        vecs.push_back(mkv(32'h04, 1, 1, 0, 1, 0, 32'h08));
        vecs.push_back(mkv(32'h04, 1, 1, 0, 1, 1, 32'h08));
        vecs.push_back(mkv(32'h04, 1, 1, 0, 1, 1, 32'h08));
        vecs.push_back(mkv(32'h04, 1, 0, 0, 1, 1, 32'h08));
        vecs.push_back(mkv(32'h05, 1, 0, 0, 1, 0, 32'h0C));
        vecs.push_back(mkv(32'h06, 0, 0, 0, 1, 0, 32'h10));
        vecs.push_back(mkv(32'h06, 0, 0, 0, 1, 0, 32'h14));
        vecs.push_back(mkv(32'h06, 0, 0, 0, 0, 0, 32'h00));
        // redirect with one entry buffered and a response in flight
        vecs.push_back(mkv(32'h20, 1, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h21, 1, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h22, 1, 0, 0, 1, 0, 32'h80));
        vecs.push_back(mkv(32'h23, 1, 0, 1, 1, 0, 32'h84));
        vecs.push_back(mkv(32'h40, 1, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h41, 1, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h42, 1, 0, 0, 1, 0, 32'h100));
        // redirect with two entries buffered
        vecs.push_back(mkv(32'h43, 1, 1, 0, 1, 0, 32'h104));
        vecs.push_back(mkv(32'h44, 1, 1, 1, 1, 1, 32'h104));
        vecs.push_back(mkv(32'h50, 1, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h51, 0, 0, 0, 0, 0, 32'h00));
        vecs.push_back(mkv(32'h52, 0, 0, 0, 1, 0, 32'h140));
        vecs.push_back(mkv(32'h52, 0, 0, 0, 0, 0, 32'h00));

        // reset state, Imem_Req still follows the inputs during reset
        rst_n         = 1'b0;
        bus.PC_In     = 32'h0000_0007;
        bus.En_PC     = 1'b1;
        bus.stall_pc  = 1'b0;
        bus.PC_Change = 1'b0;
        bus.Imem_Data = 32'hDEAD_BEEF;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", 32'(bus.Valid_ID), 32'd0);
        chk("rst_instr", bus.Instr_ID, NOP);
        chk("rst_pc",    bus.PC_ID, 32'd0);
        chk("rst_pc4",   bus.PC4_ID, 32'd0);
        chk("rst_full",  32'(bus.Buf_Full), 32'd0);
        chk("rst_ovf",   32'(bus.Ovf_Err), 32'd0);
        chk("rst_req",   32'(bus.Imem_Req), 32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i], 1'b1);

        // PC wrap at the top of the word-index range
        run(32'h3FFF_FFFF, 1, 0, 0);
        run(32'h0, 0, 0, 0);
        chk("wrap_valid", 32'(bus.Valid_ID), 32'd1);
        chk("wrap_pc",    bus.PC_ID, 32'hFFFF_FFFC);
        chk("wrap_pc4",   bus.PC4_ID, 32'h0000_0000);
        run(32'h0, 0, 0, 0);

        // overflow: push forced into a full FIFO while decode is stalled
        run(32'h60, 1, 0, 0);
        run(32'h61, 1, 0, 0);
        run(32'h62, 1, 1, 0);
        force dut.rsp_vld_reg = 1'b1;
        run(32'h62, 1, 1, 0);
        release dut.rsp_vld_reg;
        ovf_exp = 1'b1;
        chk("ovf_set",  32'(bus.Ovf_Err), 32'd1);
        chk("ovf_full", 32'(bus.Buf_Full), 32'd1);
        chk("ovf_head", bus.PC_ID, 32'h180);
        run(32'h62, 1, 1, 0);
        run(32'h62, 1, 0, 0);
        run(32'h63, 1, 0, 0);
        run(32'h63, 0, 0, 0);
        run(32'h63, 0, 0, 0);
        run(32'h63, 0, 0, 0);

        // asynchronous reset between edges with two entries buffered
        run(32'h80, 1, 0, 0);
        run(32'h81, 1, 0, 0);
        run(32'h82, 1, 1, 0);
        chk("pre_rst_full", 32'(bus.Buf_Full), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.Valid_ID), 32'd0);
        chk("arst_instr", bus.Instr_ID, NOP);
        chk("arst_pc",    bus.PC_ID, 32'd0);
        chk("arst_pc4",   bus.PC4_ID, 32'd0);
        chk("arst_full",  32'(bus.Buf_Full), 32'd0);
        chk("arst_ovf",   32'(bus.Ovf_Err), 32'd0);
        sb.delete();
        ovf_exp = 1'b0;
        run(32'h83, 1, 0, 0);
        rst_n = 1'b1;
        run(32'h84, 1, 0, 0);
        run(32'h85, 1, 0, 0);
        run(32'h86, 0, 0, 0);
        run(32'h86, 0, 0, 0);
        run(32'h86, 0, 0, 0);
        run(32'h86, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
